// File: rtl/awg_cfg_scheduler.sv
// awg_cfg_scheduler: shadow-buffered DDS channel config committed at the channel's phase wrap.
// Optional AWG_BROADCAST_EN: channel 8'hFF commits to every channel on ch_wrap[0].
module awg_cfg_scheduler #(
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] DEF_ADDER = 32'd1000000,
  parameter logic [31:0] DEF_AMPL  = 32'd1000000,
  parameter int          TIMEOUT   = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [7:0]             cmd_channel,
  input  logic [31:0]            cmd_adder,
  input  logic [31:0]            cmd_ampl,
  input  logic [NUM_CH-1:0]      ch_wrap,
  output logic [32*NUM_CH-1:0]   ch_adder,
  output logic [32*NUM_CH-1:0]   ch_ampl,
  output logic [NUM_CH-1:0]      ch_update,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [7:0] NCH = 8'(NUM_CH);
  typedef enum logic [1:0] {IDLE, WAIT_WRAP, RESP} state_t;
  state_t state, nxt;
  logic [7:0] sh_ch, stat;
  logic [31:0] sh_adder, sh_ampl;
  logic [CW-1:0] cnt;
  logic [NUM_CH-1:0] sel;
  logic cmd_bcast, bcast, wrap_hit, timeout_hit, commit;
`ifdef AWG_BROADCAST_EN
  assign cmd_bcast = cmd_channel == 8'hFF;
  assign bcast = sh_ch == 8'hFF;
`else
  assign cmd_bcast = 1'b0;
  assign bcast = 1'b0;
`endif
  // one-hot target mask derived from the shadow channel
  for (genvar i = 0; i < NUM_CH; i++) begin : g_sel
    assign sel[i] = bcast || sh_ch == 8'(i);
  end
  assign wrap_hit = bcast ? ch_wrap[0] : |(ch_wrap & sel);
  assign timeout_hit = cnt == CW'(TIMEOUT - 1);
  assign cmd_ready = state == IDLE && !rst;
  always_comb begin
    nxt = state;
    commit = 1'b0;
    stat = 8'h00;
    case (state)
      IDLE: begin
        if (cmd_valid) nxt = (cmd_channel < NCH || cmd_bcast) ? WAIT_WRAP : RESP;
        stat = 8'h78;
      end
      WAIT_WRAP: begin
        commit = wrap_hit || timeout_hit;
        nxt = commit ? RESP : WAIT_WRAP;
        stat = wrap_hit ? 8'h6B : 8'h74;
      end
      RESP: nxt = tx_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh_ch <= 8'h00;
      sh_adder <= 32'h0;
      sh_ampl <= 32'h0;
      cnt <= '0;
      ch_adder <= {NUM_CH{DEF_ADDER}};
      ch_ampl <= {NUM_CH{DEF_AMPL}};
      ch_update <= '0;
      tx_valid <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      state <= nxt;
      ch_update <= commit ? sel : '0;
      if (state == IDLE && cmd_valid) begin
        sh_ch <= cmd_channel;
        sh_adder <= cmd_adder;
        sh_ampl <= cmd_ampl;
        cnt <= '0;
      end else if (state == WAIT_WRAP) cnt <= cnt + 1'b1;
      for (int i = 0; i < NUM_CH; i++)
        if (commit && sel[i]) begin
          ch_adder[32*i +: 32] <= sh_adder;
          ch_ampl[32*i +: 32] <= sh_ampl;
        end
      if (nxt == RESP && state != RESP) begin
        tx_valid <= 1'b1;
        tx_data <= stat;
      end else if (state == RESP && tx_ready) tx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_awg_cfg_scheduler.sv
// tb_awg_cfg_scheduler: directed checks of commit-on-wrap, bad channel, timeout, reset abort and broadcast.
module tb_awg_cfg_scheduler;
  localparam logic [31:0] DEF = 32'd1000000;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, tx_valid, tx_ready = 1'b0;
  logic [7:0] cmd_channel = 8'h00, tx_data;
  logic [31:0] cmd_adder = 32'h0, cmd_ampl = 32'h0;
  logic [3:0] ch_wrap = 4'b0, ch_update;
  logic [127:0] ch_adder, ch_ampl;
  int checks = 0, errors = 0;
  awg_cfg_scheduler #(.NUM_CH(4), .DEF_ADDER(DEF), .DEF_AMPL(DEF), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_channel(cmd_channel), .cmd_adder(cmd_adder), .cmd_ampl(cmd_ampl),
    .ch_wrap(ch_wrap), .ch_adder(ch_adder), .ch_ampl(ch_ampl), .ch_update(ch_update),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] ch, input logic [31:0] a, input logic [31:0] m);
    cmd_valid = 1'b1;
    cmd_channel = ch;
    cmd_adder = a;
    cmd_ampl = m;
  endtask
  task automatic chan(input string tag, input int i, input logic [31:0] a, input logic [31:0] m);
    chk({tag, "_adder"}, ch_adder[32*i +: 32], a);
    chk({tag, "_ampl"}, ch_ampl[32*i +: 32], m);
  endtask
  initial begin
    logic [7:0] held;
    repeat (2) cyc();
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_upd", 32'(ch_update), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) chan("rst_ch", i, DEF, DEF);
    // commit on channel 2 wrap, with a wrap at acceptance and a foreign wrap ignored
    send(8'd2, 32'h00010000, 32'h0000FFFF);
    ch_wrap = 4'b0100;
    cyc();
    cmd_valid = 1'b0;
    ch_wrap = 4'b0010;
    chk("wait_ready", 32'(cmd_ready), 32'd0);
    chk("wait_txv", 32'(tx_valid), 32'd0);
    cyc();
    ch_wrap = 4'b0000;
    chk("foreign_wrap_txv", 32'(tx_valid), 32'd0);
    chk("foreign_wrap_upd", 32'(ch_update), 32'd0);
    repeat (8) cyc();
    chan("pre_wrap_ch2", 2, DEF, DEF);
    ch_wrap = 4'b0100;
    cyc();
    ch_wrap = 4'b0000;
    chk("wrap_upd", 32'(ch_update), 32'h4);
    chk("wrap_txv", 32'(tx_valid), 32'd1);
    chk("wrap_txd", 32'(tx_data), 32'h6B);
    chan("wrap_ch2", 2, 32'h00010000, 32'h0000FFFF);
    chan("wrap_ch0", 0, DEF, DEF);
    chan("wrap_ch1", 1, DEF, DEF);
    chan("wrap_ch3", 3, DEF, DEF);
    cyc();
    chk("upd_one_cycle", 32'(ch_update), 32'd0);
    chk("resp_hold_txv", 32'(tx_valid), 32'd1);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    chk("resp_done_txv", 32'(tx_valid), 32'd0);
    chk("resp_done_ready", 32'(cmd_ready), 32'd1);
    // out-of-range channel, status held under backpressure
    send(8'd5, 32'h12345678, 32'h9ABCDEF0);
    cyc();
    cmd_valid = 1'b0;
    chk("bad_txv", 32'(tx_valid), 32'd1);
    chk("bad_txd", 32'(tx_data), 32'h78);
    chk("bad_upd", 32'(ch_update), 32'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bad_hold_txv", 32'(tx_valid), 32'd1);
      chk("bad_hold_txd", 32'(tx_data), 32'h78);
      chk("bad_hold_ready", 32'(cmd_ready), 32'd0);
      chk("bad_hold_upd", 32'(ch_update), 32'd0);
    end
    chan("bad_ch2", 2, 32'h00010000, 32'h0000FFFF);
    chan("bad_ch1", 1, DEF, DEF);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    chk("bad_done_txv", 32'(tx_valid), 32'd0);
    // forced commit after 16 waiting cycles
    send(8'd1, 32'h00000111, 32'h00000222);
    cyc();
    cmd_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("to_wait_txv", 32'(tx_valid), 32'd0);
      cyc();
    end
    chk("to_last_txv", 32'(tx_valid), 32'd0);
    chan("to_pre_ch1", 1, DEF, DEF);
    cyc();
    chk("to_txv", 32'(tx_valid), 32'd1);
    chk("to_txd", 32'(tx_data), 32'h74);
    chk("to_upd", 32'(ch_update), 32'h2);
    chan("to_ch1", 1, 32'h00000111, 32'h00000222);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    // wrap landing in the timeout cycle wins
    send(8'd1, 32'h00000333, 32'h00000444);
    cyc();
    cmd_valid = 1'b0;
    repeat (15) cyc();
    ch_wrap = 4'b0010;
    cyc();
    ch_wrap = 4'b0000;
    chk("tie_txd", 32'(tx_data), 32'h6B);
    chk("tie_upd", 32'(ch_update), 32'h2);
    chan("tie_ch1", 1, 32'h00000333, 32'h00000444);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    // reset while waiting drops everything
    send(8'd0, 32'h0000AAAA, 32'h0000BBBB);
    cyc();
    cmd_valid = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(cmd_ready), 32'd0);
    chk("abort_txv", 32'(tx_valid), 32'd0);
    chan("abort_ch1", 1, DEF, DEF);
    chan("abort_ch2", 2, DEF, DEF);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      ch_wrap = (k == 3) ? 4'b0001 : 4'b0000;
      cyc();
      chk("abort_after_txv", 32'(tx_valid), 32'd0);
      chk("abort_after_upd", 32'(ch_update), 32'd0);
    end
    chan("abort_after_ch0", 0, DEF, DEF);
    chk("abort_after_ready", 32'(cmd_ready), 32'd1);
    // channel 8'hFF
    send(8'hFF, 32'hAAAA0000, 32'h00005555);
    cyc();
    cmd_valid = 1'b0;
`ifdef AWG_BROADCAST_EN
    ch_wrap = 4'b0001;
    cyc();
    ch_wrap = 4'b0000;
    chk("bc_upd", 32'(ch_update), 32'hF);
    chk("bc_txd", 32'(tx_data), 32'h6B);
    for (int i = 0; i < 4; i++) chan("bc_ch", i, 32'hAAAA0000, 32'h00005555);
`else
    chk("ff_txv", 32'(tx_valid), 32'd1);
    chk("ff_txd", 32'(tx_data), 32'h78);
    chk("ff_upd", 32'(ch_update), 32'd0);
    for (int i = 0; i < 4; i++) chan("ff_ch", i, DEF, DEF);
`endif
    held = tx_data;
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    chk("ff_done_txv", 32'(tx_valid), 32'd0);
    chk("ff_done_txd_kept", 32'(tx_data), 32'(held));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/awg_cfg_scheduler.md
# awg_cfg_scheduler

Configuration scheduler between the UART command parser and the per-channel DDS phase accumulators. Accepts one parsed command (channel number, phase increment, amplitude) at a time, holds it in shadow registers, and commits it to the addressed channel's live registers only at that channel's phase-wrap, so waveforms change glitch-free. After every command it returns a one-byte status to the UART transmitter.

## Interface
- NUM_CH, 4: number of DDS channels (1..8)
- DEF_ADDER, 32'd1000000: reset value of every live phase increment
- DEF_AMPL, 32'd1000000: reset value of every live amplitude
- TIMEOUT, 65535: max cycles to wait for a wrap before forced commit (≥2)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present from parser
- cmd_ready  out  1  scheduler can accept a command
- cmd_channel  in  8  target channel number
- cmd_adder  in  32  new phase increment
- cmd_ampl  in  32  new amplitude
- ch_wrap  in  NUM_CH  one-cycle pulse per channel at accumulator wrap
- ch_adder  out  32*NUM_CH  live phase increments, channel i at [32i+31:32i]
- ch_ampl  out  32*NUM_CH  live amplitudes, same packing
- ch_update  out  NUM_CH  one-cycle pulse: channel's live values changed
- tx_valid  out  1  status byte available
- tx_data  out  8  status byte
- tx_ready  in  1  UART TX accepts byte

## Operation
- Reset values: cmd_ready 0 during rst, 1 first cycle after; ch_adder all DEF_ADDER; ch_ampl all DEF_AMPL; ch_update 0; tx_valid 0; tx_data 0; timeout counter 0; state IDLE.
- States: IDLE, WAIT_WRAP, RESP.
- IDLE: cmd_ready=1. Accept on cmd_valid&cmd_ready: capture channel/adder/ampl into shadow registers.
  - cmd_channel < NUM_CH -> WAIT_WRAP, counter cleared.
  - otherwise -> RESP, status 'x' (8'h78); live registers untouched.
- WAIT_WRAP: cmd_ready=0; counter increments each cycle.
  - ch_wrap[ch]=1 -> commit shadow to channel ch, status 'k' (8'h6B), -> RESP.
  - else counter==TIMEOUT-1 -> forced commit, status 't' (8'h74), -> RESP.
  - Wrap and timeout same cycle -> status 'k'.
  - Wraps on other channels ignored.
- RESP: tx_valid=1, tx_data stable until tx_valid&tx_ready; then -> IDLE, tx_valid 0.
- Commit: live registers and ch_update[ch] registered on the same edge that enters RESP; ch_update high exactly one cycle.
- Only one command in flight; no queueing; parser stalls on cmd_ready=0.
- rst mid-operation: shadow discarded, pending commit and pending status dropped, all live values return to defaults.

## Timing
- Accept edge E0. Earliest ch_wrap sampled is cycle after E0; a wrap coincident with acceptance is ignored.
- Wrap sampled in cycle N -> ch_adder/ch_ampl/ch_update/tx_valid all change at edge ending cycle N.
- Bad channel: tx_valid high first cycle after E0.
- Timeout: forced commit TIMEOUT cycles after entering WAIT_WRAP.
- tx_ready high in first RESP cycle -> back in IDLE, cmd_ready=1 the next cycle; minimum command-to-command spacing 3 cycles.

## Configuration
- AWG_BROADCAST_EN defined: cmd_channel==8'hFF is valid; shadow committed to all NUM_CH channels simultaneously on ch_wrap[0] (or timeout); all ch_update bits pulse together; status 'k'/'t' as usual.
- Not defined: 8'hFF treated as any other out-of-range channel -> status 'x', no commit.

## Test plan
- Reset, no commands -> every ch_adder/ch_ampl = 1000000, tx_valid 0, cmd_ready 1 after rst deasserts.
- Command ch=2, adder=32'h00010000, ampl=32'h0000FFFF; ch_wrap[2] pulsed 10 cycles later -> values appear on channel 2 at that edge, ch_update=4'b0100 one cycle, tx_data 8'h6B; channels 0,1,3 unchanged.
- Command ch=5 with NUM_CH=4 -> tx_data 8'h78 next cycle, no ch_update, live values unchanged; hold tx_ready=0 for 5 cycles -> tx_valid/tx_data stable, cmd_ready 0.
- TIMEOUT=16, command ch=1, no wrap -> forced commit 16 cycles after WAIT_WRAP entry, tx_data 8'h74; repeat with ch_wrap[1] in the 16th cycle -> 8'h6B.
- Command ch=0 then assert rst while in WAIT_WRAP -> all outputs at reset values, no status byte emitted after release.
- With AWG_BROADCAST_EN, ch=8'hFF, ch_wrap[0] -> all four channels updated, ch_update=4'b1111; without macro -> 8'h78.
